// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states and Booth recoding encodings for booth_mult_param
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {R4_ZERO, R4_POS1, R4_POS2, R4_NEG1, R4_NEG2} r4_sel_e;
  localparam logic [1:0] R2_ADD = 2'b01;
  localparam logic [1:0] R2_SUB = 2'b10;
endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: maps a {Q1,Q0,Q[-1]} group to its modified-Booth partial-product select
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output r4_sel_e    sel
);
  assign sel = (grp == 3'b001 || grp == 3'b010) ? R4_POS1 :
               (grp == 3'b011)                  ? R4_POS2 :
               (grp == 3'b100)                  ? R4_NEG2 :
               (grp == 3'b101 || grp == 3'b110) ? R4_NEG1 : R4_ZERO;
endmodule

// File: rtl/booth_mult_param.sv
// booth_mult_param: sequential signed Booth multiplier, radix-2 or radix-4, start/busy/done handshake
module booth_mult_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RADIX4 = 0,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  output logic [2*WIDTH-1:0] result,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done
);
  localparam int N  = RADIX4 != 0 ? WIDTH / 2 : WIDTH;
  localparam int SH = RADIX4 != 0 ? 2 : 1;
  // Extra accumulator headroom keeps -M of the most negative operand and +-2M exact
  localparam int AW = RADIX4 != 0 ? WIDTH + 2 : WIDTH + 1;
  localparam int TW = AW + WIDTH + 1;
  state_e            state, state_nx;
  r4_sel_e           r4_sel;
  logic [WIDTH-1:0]  m, q;
  logic [AW-1:0]     a, m_ext, m2, addend, sum;
  logic              q_1;
  logic [TW-1:0]     shifted;
  if (RADIX4 != 0) begin : g_r4
    booth_r4_recoder u_rec (.grp({q[1], q[0], q_1}), .sel(r4_sel));
  end else begin : g_r2
    assign r4_sel = R4_ZERO;
  end
  assign m_ext = {{(AW-WIDTH){m[WIDTH-1]}}, m};
  assign m2 = m_ext << 1;
  assign addend = (RADIX4 != 0) ?
      (r4_sel == R4_POS1 ? m_ext : r4_sel == R4_POS2 ? m2 :
       r4_sel == R4_NEG1 ? -m_ext : r4_sel == R4_NEG2 ? -m2 : '0) :
      ({q[0], q_1} == R2_ADD ? m_ext : {q[0], q_1} == R2_SUB ? -m_ext : '0);
  assign sum = a + addend;
  assign shifted = $signed({sum, q, q_1}) >>> SH;
  always_comb begin
    state_nx = state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (count == CNT_W'(N - 1) ? DONE : CALC) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      m      <= '0;
      q      <= '0;
      a      <= '0;
      q_1    <= 1'b0;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        m     <= input1;
        q     <= input2;
        a     <= '0;
        q_1   <= 1'b0;
        count <= '0;
      end else if (state == CALC) begin
        a     <= shifted[TW-1 -: AW];
        q     <= shifted[WIDTH:1];
        q_1   <= shifted[0];
        count <= count + CNT_W'(1);
        // Final iteration: capture the product so it is valid throughout DONE
        if (count == CNT_W'(N - 1)) result <= shifted[2*WIDTH:1];
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_param.sv
// tb_booth_mult_param: scoreboard bench over four width/radix configurations against an integer product model
module tb_booth_mult_param;
  typedef struct {int g; logic [15:0] res; int cnt; int cyc;} exp_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] in1 [4];
  logic [7:0] in2 [4];
  logic       start [4];
  logic       busy [4];
  logic       done [4];
  logic [15:0] res [4];
  logic [3:0]  cnt [4];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W = g < 2 ? 4 : 8;
    localparam int CW = $clog2(W + 1);
    logic [2*W-1:0] r;
    logic [CW-1:0]  c;
    booth_mult_param #(.WIDTH(W), .RADIX4(g % 2)) dut (
      .clk(clk), .reset(rst_n), .start(start[g]),
      .input1(in1[g][W-1:0]), .input2(in2[g][W-1:0]),
      .result(r), .count(c), .busy(busy[g]), .done(done[g]));
    assign res[g] = 16'(r);
    assign cnt[g] = 4'(c);
  end
  function automatic int wid(int g);
    return g < 2 ? 4 : 8;
  endfunction
  function automatic int nit(int g);
    return wid(g) / (g % 2 == 1 ? 2 : 1);
  endfunction
  function automatic longint sx(int v, int w);
    longint x = longint'(v) & ((longint'(1) << w) - 1);
    return x >= (longint'(1) << (w - 1)) ? x - (longint'(1) << w) : x;
  endfunction
  function automatic logic [15:0] ref_prod(int w, int a, int b);
    longint p = sx(a, w) * sx(b, w);
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction
  function automatic void push(int g, int a, int b, int c);
    exp_t x;
    x.g = g; x.res = ref_prod(wid(g), a, b); x.cnt = nit(g); x.cyc = c;
    sb.push_back(x);
  endfunction
  task automatic wait_idle(input int g, output int bc);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy[g]) break;
      bc++;
    end
  endtask
  task automatic do_op(input int g, input int a, input int b);
    int bc;
    @(negedge clk);
    in1[g] = 8'(a); in2[g] = 8'(b); start[g] = 1;
    @(posedge clk); #1;
    start[g] = 0;
    push(g, a, b, cyc + nit(g));
    in1[g] = 8'($urandom); in2[g] = 8'($urandom);
    wait_idle(g, bc);
    nvec++;
    if (bc != nit(g) + 1) begin
      nerr++;
      $display("FAIL busy_len inst%0d a=%0d b=%0d got %0d cycles want %0d", g, a, b, bc, nit(g) + 1);
    end
  endtask
  task automatic held_op(input int g, input int a, input int b, input int c, input int d);
    int c0, bc;
    @(negedge clk);
    in1[g] = 8'(a); in2[g] = 8'(b); start[g] = 1;
    @(posedge clk); #1;
    c0 = cyc;
    push(g, a, b, c0 + nit(g));
    in1[g] = 8'(c); in2[g] = 8'(d);
    repeat (nit(g) + 2) @(negedge clk);
    nvec++;
    if (busy[g]) begin
      nerr++;
      $display("FAIL idle_gap inst%0d busy=%0b want 0 at cycle %0d", g, busy[g], cyc);
    end
    @(posedge clk); #1;
    push(g, c, d, cyc + nit(g));
    start[g] = 0;
    wait_idle(g, bc);
  endtask
  task automatic check_zero(input int g, input string tag);
    nvec++;
    if (res[g] !== 16'd0 || cnt[g] !== 4'd0 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
      nerr++;
      $display("FAIL %s inst%0d got res=%h cnt=%0d busy=%0b done=%0b want all zero",
               tag, g, res[g], cnt[g], busy[g], done[g]);
    end
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    for (int g = 0; g < 4; g++) begin
      in1[g] = 0; in2[g] = 0; start[g] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) if (done[g] === 1'b1) begin
          nvec++;
          if (sb.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_done inst%0d res=%h cnt=%0d at cycle %0d", g, res[g], cnt[g], cyc);
          end else begin
            e = sb.pop_front();
            if (e.g != g || res[g] !== e.res || cnt[g] != e.cnt || cyc != e.cyc) begin
              nerr++;
              $display("FAIL product inst%0d got res=%h cnt=%0d cyc=%0d want inst%0d res=%h cnt=%0d cyc=%0d",
                       g, res[g], cnt[g], cyc, e.g, e.res, e.cnt, e.cyc);
            end
          end
        end
      end
    join_none
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) check_zero(g, "reset_low");
    rst_n = 1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) check_zero(g, "reset_idle");
    do_op(0, 6, 3);
    do_op(1, 6, 3);
    for (int g = 0; g < 2; g++) begin
      do_op(g, -8, -8);
      do_op(g, -8, 7);
      do_op(g, 0, -5);
    end
    for (int g = 2; g < 4; g++) begin
      do_op(g, 127, -128);
      do_op(g, -128, -128);
    end
    do_op(0, 7, 7);
    @(negedge clk);
    in1[0] = 8'(6); in2[0] = 8'(7); start[0] = 1;
    @(posedge clk); #1;
    start[0] = 0;
    for (int i = 0; i < 10 && cnt[0] != 4'd2; i++) @(negedge clk);
    rst_n = 0;
    #1;
    check_zero(0, "reset_mid_calc");
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    do_op(0, 5, -3);
    held_op(1, 3, -7, -6, 5);
    held_op(3, -100, 77, 55, -128);
    held_op(0, -1, -8, 7, -2);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        do_op(0, a, b);
        do_op(1, a, b);
      end
    for (int i = 0; i < 150; i++)
      for (int g = 2; g < 4; g++) begin
        int a, b;
        a = ($urandom % 4 == 0) ? (($urandom % 2) ? 128 : 127) : int'($urandom_range(0, 255));
        b = ($urandom % 4 == 0) ? (($urandom % 2) ? 0 : 255) : int'($urandom_range(0, 255));
        do_op(g, a, b);
      end
    repeat (5) @(negedge clk);
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d outstanding results want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
